// File: rtl/simcomp_mem_unit.sv
// simcomp_mem_unit: word-addressed DEPTH x DATA_W main memory with req/ack handshake and a load port
// Core port : req/we/addr/wdata in, rdata/ack/err/busy out; ack is a one-cycle pulse,
//             err accompanies ack for out-of-range addresses (and parity faults).
// Load port : ld_valid/ld_addr/ld_data in, ld_ready out; accepted only while idle with no req.
// Option    : define MEM_PARITY_EN for a per-word even-parity bit and the par_inject input.
module simcomp_mem_unit #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              err,
  output logic              busy,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready
`ifdef MEM_PARITY_EN
  ,
  input  logic              par_inject
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  state_t state;
  logic [3:0] cnt;
  logic we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] mem [DEPTH];
  logic in_range, ld_in_range, core_wr, ld_wr, bad;
  assign in_range    = 32'(addr_q) < DEPTH;
  assign ld_in_range = 32'(ld_addr) < DEPTH;
  assign ld_ready    = (state == IDLE) && !req && !reset;
  assign core_wr     = (state == ACCESS) && we_q && in_range && !reset;
  assign ld_wr       = ld_valid && ld_ready && ld_in_range;
`ifdef MEM_PARITY_EN
  logic par [DEPTH];
  assign bad = !in_range || (!we_q && ((^mem[addr_q[AW-1:0]]) != par[addr_q[AW-1:0]]));
  always_ff @(posedge clock) begin
    if (core_wr) par[addr_q[AW-1:0]] <= (^wdata_q) ^ par_inject;
    else if (ld_wr) par[ld_addr[AW-1:0]] <= (^ld_data) ^ par_inject;
  end
`else
  assign bad = !in_range;
`endif
  // Array is deliberately outside the reset domain: contents survive reset.
  always_ff @(posedge clock) begin
    if (core_wr) mem[addr_q[AW-1:0]] <= wdata_q;
    else if (ld_wr) mem[ld_addr[AW-1:0]] <= ld_data;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      rdata <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: if (req) begin
          we_q    <= we;
          addr_q  <= addr;
          wdata_q <= wdata;
          busy    <= 1'b1;
          cnt     <= WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
          state   <= WAIT_STATES == 0 ? ACCESS : WAIT;
        end
        WAIT: begin
          cnt   <= cnt - 4'd1;
          state <= cnt == 4'd0 ? ACCESS : WAIT;
        end
        ACCESS: begin
          if (!we_q && in_range) rdata <= mem[addr_q[AW-1:0]];
          ack   <= 1'b1;
          err   <= bad;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
